// File: rtl/execute_stage.sv
// EX pipeline stage: ALU, branch/jump resolution, EX/MEM register, PC redirect,
// wrong-path squash window and a saturating taken-redirect counter.
module execute_stage #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemtoReg,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             branch,
  input  logic             jump,
  input  logic [2:0]       ALUctr,
  input  logic [31:0]      A,
  input  logic [31:0]      B,
  input  logic [15:0]      imm,
  input  logic [31:0]      NPC,
  input  logic [31:0]      JT,
  input  logic [31:0]      MD,
  input  logic [4:0]       RD,
  output logic             XM_MemtoReg,
  output logic             XM_RegWrite,
  output logic             XM_MemRead,
  output logic             XM_MemWrite,
  output logic [31:0]      XM_ALUout,
  output logic [31:0]      XM_MD,
  output logic [4:0]       XM_RD,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             squashing,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] FLUSH_LD = 2'(FLUSH_DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic [31:0]        alu_res;
  logic               zero;
  logic               br_taken;
  logic               taken;
  logic [31:0]        br_off;
  logic [31:0]        target;
  logic [1:0]         sq_cnt_p1;
  logic [1:0]         sq_next;
  logic               squash;
  logic               issue;

  assign a_s = A;
  assign b_s = B;

  always_comb begin
    alu_res = '0;
    case (ALUctr)
      3'b010:          alu_res = A + B;
      3'b110, 3'b101:  alu_res = A - B;
      3'b000:          alu_res = A & B;
      3'b001:          alu_res = A | B;
      3'b111:          alu_res = {31'b0, (a_s < b_s)};
      default:         alu_res = '0;
    endcase
  end

  assign zero     = (alu_res == 32'd0);
  assign br_taken = branch && (((ALUctr == 3'b101) && zero) || ((ALUctr == 3'b110) && !zero));
  assign taken    = jump || br_taken;
  assign br_off   = {{14{imm[15]}}, imm, 2'b00};
  assign target   = jump ? JT : (NPC + br_off);

  // A nonzero window blocks everything, including a redirect from a wrong-path branch.
  assign squash = (sq_cnt_p1 != 2'd0);
  assign issue  = taken && !squash;

  always_comb begin
    sq_next = sq_cnt_p1;
    if (squash)     sq_next = sq_cnt_p1 - 2'd1;
    else if (issue) sq_next = FLUSH_LD;
  end

  // EX/MEM register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      XM_MemtoReg <= 1'b0;
      XM_RegWrite <= 1'b0;
      XM_MemRead  <= 1'b0;
      XM_MemWrite <= 1'b0;
      XM_ALUout   <= '0;
      XM_MD       <= '0;
      XM_RD       <= '0;
      pc_redirect <= 1'b0;
      pc_target   <= '0;
      sq_cnt_p1   <= '0;
      squashing   <= 1'b0;
      taken_cnt   <= '0;
    end else begin
      XM_MemtoReg <= MemtoReg && !squash;
      XM_RegWrite <= RegWrite && !squash;
      XM_MemRead  <= MemRead  && !squash;
      XM_MemWrite <= MemWrite && !squash;
      XM_ALUout   <= alu_res;
      XM_MD       <= MD;
      XM_RD       <= RD;
      pc_redirect <= issue;
      if (issue) pc_target <= target;
      sq_cnt_p1   <= sq_next;
      squashing   <= (sq_next != 2'd0);
      if (issue) taken_cnt <= sat_inc(taken_cnt);
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized traffic against a
// cycle-level reference model; a CNT_W=2 twin shares the inputs to exercise saturation.
module tb_execute_stage;

  localparam int FD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        MemtoReg, RegWrite, MemRead, MemWrite, branch, jump;
  logic [2:0]  ALUctr;
  logic [31:0] A, B, NPC, JT, MD;
  logic [15:0] imm;
  logic [4:0]  RD;

  logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
  logic [31:0] XM_ALUout, XM_MD, pc_target;
  logic [4:0]  XM_RD;
  logic        pc_redirect, squashing;
  logic [15:0] taken_cnt;

  logic        s_MemtoReg, s_RegWrite, s_MemRead, s_MemWrite;
  logic [31:0] s_ALUout, s_MD, s_target;
  logic [4:0]  s_RD;
  logic        s_redirect, s_squashing;
  logic [1:0]  s_taken_cnt;

  execute_stage #(.FLUSH_DEPTH(FD), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .branch(branch), .jump(jump), .ALUctr(ALUctr), .A(A), .B(B), .imm(imm),
    .NPC(NPC), .JT(JT), .MD(MD), .RD(RD),
    .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite), .XM_MemRead(XM_MemRead),
    .XM_MemWrite(XM_MemWrite), .XM_ALUout(XM_ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .squashing(squashing),
    .taken_cnt(taken_cnt)
  );

  execute_stage #(.FLUSH_DEPTH(FD), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .branch(branch), .jump(jump), .ALUctr(ALUctr), .A(A), .B(B), .imm(imm),
    .NPC(NPC), .JT(JT), .MD(MD), .RD(RD),
    .XM_MemtoReg(s_MemtoReg), .XM_RegWrite(s_RegWrite), .XM_MemRead(s_MemRead),
    .XM_MemWrite(s_MemWrite), .XM_ALUout(s_ALUout), .XM_MD(s_MD), .XM_RD(s_RD),
    .pc_redirect(s_redirect), .pc_target(s_target), .squashing(s_squashing),
    .taken_cnt(s_taken_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [3:0]  e_ctl;
  logic [31:0] e_alu, e_md, e_tgt;
  logic [4:0]  e_rd;
  logic        e_redir, e_sq;
  int          m_sq;
  int          m_taken;

  task automatic model_reset();
    e_ctl = '0; e_alu = '0; e_md = '0; e_tgt = '0; e_rd = '0;
    e_redir = 1'b0; e_sq = 1'b0; m_sq = 0; m_taken = 0;
  endtask

  task automatic model_clock();
    logic [31:0] res;
    logic [31:0] tgt;
    logic        tk;
    case (ALUctr)
      3'd2:       res = A + B;
      3'd5, 3'd6: res = A - B;
      3'd0:       res = A & B;
      3'd1:       res = A | B;
      3'd7:       res = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      default:    res = 32'd0;
    endcase
    if (jump) begin
      tk  = 1'b1;
      tgt = JT;
    end else begin
      tk  = branch && ((ALUctr == 3'd5 && res == 0) || (ALUctr == 3'd6 && res != 0));
      tgt = NPC + 32'(int'($signed(imm)) * 4);
    end
    e_alu = res; e_md = MD; e_rd = RD;
    if (m_sq > 0) begin
      e_ctl = '0; e_redir = 1'b0; m_sq--;
    end else begin
      e_ctl   = {MemtoReg, RegWrite, MemRead, MemWrite};
      e_redir = tk;
      if (tk) begin
        e_tgt = tgt; m_sq = FD; m_taken++;
      end
    end
    e_sq = (m_sq != 0);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".ctl"}, {28'b0, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite}, {28'b0, e_ctl});
    chk({tag, ".alu"}, XM_ALUout, e_alu);
    chk({tag, ".md"}, XM_MD, e_md);
    chk({tag, ".rd"}, {27'b0, XM_RD}, {27'b0, e_rd});
    chk({tag, ".redir"}, {31'b0, pc_redirect}, {31'b0, e_redir});
    chk({tag, ".tgt"}, pc_target, e_tgt);
    chk({tag, ".sq"}, {31'b0, squashing}, {31'b0, e_sq});
    chk({tag, ".cnt"}, {16'b0, taken_cnt}, 32'((m_taken > 65535) ? 65535 : m_taken));
    chk({tag, ".scnt"}, {30'b0, s_taken_cnt}, 32'((m_taken > 3) ? 3 : m_taken));
    chk({tag, ".sctl"}, {28'b0, s_MemtoReg, s_RegWrite, s_MemRead, s_MemWrite}, {28'b0, e_ctl});
    chk({tag, ".sredir"}, {31'b0, s_redirect}, {31'b0, e_redir});
  endtask

  task automatic set_ins(input logic [3:0] ctl, input logic br, input logic jp,
                         input logic [2:0] ctr, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] im, input logic [31:0] npc, input logic [31:0] jt);
    {MemtoReg, RegWrite, MemRead, MemWrite} = ctl;
    branch = br; jump = jp; ALUctr = ctr; A = a; B = b; imm = im; NPC = npc; JT = jt;
    MD = $urandom; RD = 5'($urandom);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    compare_all(tag);
  endtask

  task automatic filler(input string tag);
    set_ins(4'b0101, 1'b0, 1'b0, 3'b010, $urandom, $urandom, 16'($urandom), $urandom, $urandom);
    step(tag);
  endtask

  initial begin
    rst = 1'b1;
    set_ins(4'b0000, 1'b0, 1'b0, 3'b000, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    compare_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // ALU spot checks
    set_ins(4'b0100, 1'b0, 1'b0, 3'b010, 32'd1, 32'd2, 0, 0, 0);
    step("add");
    chk("add_const", XM_ALUout, 32'd3);
    set_ins(4'b0100, 1'b0, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
    step("slt");
    chk("slt_const", XM_ALUout, 32'd1);
    set_ins(4'b0100, 1'b0, 1'b0, 3'b110, 32'd0, 32'd1, 0, 0, 0);
    step("sub");
    chk("sub_const", XM_ALUout, 32'hFFFF_FFFF);

    // beq taken with backward offset
    set_ins(4'b0000, 1'b1, 1'b0, 3'b101, 32'd5, 32'd5, 16'hFFFE, 32'h40, 32'hDEAD_0000);
    step("beq");
    chk("beq_redir", {31'b0, pc_redirect}, 32'd1);
    chk("beq_tgt", pc_target, 32'h38);
    chk("beq_cnt", {16'b0, taken_cnt}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      filler("beq_sq");
      chk("beq_sq_rw", {31'b0, XM_RegWrite}, 32'd0);
      chk("beq_sq_mw", {31'b0, XM_MemWrite}, 32'd0);
    end
    filler("beq_after");
    chk("after_rw", {31'b0, XM_RegWrite}, 32'd1);
    chk("after_mw", {31'b0, XM_MemWrite}, 32'd1);

    // bne not taken, then taken
    set_ins(4'b0100, 1'b1, 1'b0, 3'b110, 32'd7, 32'd7, 16'd4, 32'h100, 0);
    step("bne_nt");
    chk("bne_nt_redir", {31'b0, pc_redirect}, 32'd0);
    chk("bne_nt_sq", {31'b0, squashing}, 32'd0);
    set_ins(4'b0100, 1'b1, 1'b0, 3'b110, 32'd7, 32'd3, 16'd4, 32'h100, 0);
    step("bne_t");
    chk("bne_t_redir", {31'b0, pc_redirect}, 32'd1);
    chk("bne_t_tgt", pc_target, 32'h110);
    filler("drain");
    filler("drain");

    // jump immediately followed by a taken beq
    set_ins(4'b0100, 1'b0, 1'b1, 3'b010, 32'd1, 32'd1, 16'd8, 32'h200, 32'h0040_0020);
    step("jmp");
    chk("jmp_tgt", pc_target, 32'h0040_0020);
    set_ins(4'b0100, 1'b1, 1'b0, 3'b101, 32'd9, 32'd9, 16'd8, 32'h300, 0);
    step("jmp_beq");
    chk("jmp_beq_redir", {31'b0, pc_redirect}, 32'd0);
    chk("jmp_beq_tgt", pc_target, 32'h0040_0020);
    chk("jmp_beq_rw", {31'b0, XM_RegWrite}, 32'd0);
    chk("jmp_cnt", {16'b0, taken_cnt}, 32'd3);
    chk("sat_at3", {30'b0, s_taken_cnt}, 32'd3);
    filler("drain");
    filler("drain");

    // two more redirects: narrow counter stays saturated
    for (int i = 0; i < 2; i++) begin
      set_ins(4'b0000, 1'b0, 1'b1, 3'b000, 0, 0, 0, 0, 32'h1000 + 32'(i));
      step("satj");
      filler("drain");
      filler("drain");
    end
    chk("sat_hold", {30'b0, s_taken_cnt}, 32'd3);
    chk("wide_5", {16'b0, taken_cnt}, 32'd5);

    // async reset in the middle of a squash window
    set_ins(4'b0000, 1'b0, 1'b1, 3'b000, 0, 0, 0, 0, 32'h2000);
    step("pre_rst");
    chk("pre_rst_sq", {31'b0, squashing}, 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_mid");
    #2 rst = 1'b0;
    set_ins(4'b1111, 1'b0, 1'b0, 3'b001, 32'hF0, 32'h0F, 0, 0, 0);
    step("post_rst");
    chk("post_rst_ctl", {28'b0, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite}, 32'hF);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      set_ins(4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
              3'($urandom), ra, ($urandom_range(0, 1) == 0) ? ra : $urandom,
              16'($urandom), $urandom, $urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline EX stage, directly downstream of the instruction-decode stage; consumes its registered control and data bundle.
- Performs the ALU operation and resolves branch/jump.
- Registers the EX/MEM bundle, issues a one-cycle PC redirect to fetch, and squashes the wrong-path instructions that follow a taken branch/jump.
- Keeps a saturating taken-redirect counter for performance observation.

Parameters:
- FLUSH_DEPTH, 2, number of instructions entering EX after a taken branch/jump whose side effects are squashed (legal 0..3).
- CNT_W, 16, width of the taken-redirect counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- MemtoReg  in  1  decode: writeback selects memory data
- RegWrite  in  1  decode: register write enable
- MemRead  in  1  decode: load
- MemWrite  in  1  decode: store
- branch  in  1  decode: conditional branch
- jump  in  1  decode: unconditional jump
- ALUctr  in  3  decode: ALU operation code
- A  in  32  operand rs
- B  in  32  operand rt, or sign-extended immediate
- imm  in  16  raw immediate
- NPC  in  32  address of following instruction
- JT  in  32  jump target
- MD  in  32  store data
- RD  in  5  destination register
- XM_MemtoReg  out  1  registered MemtoReg
- XM_RegWrite  out  1  registered RegWrite
- XM_MemRead  out  1  registered MemRead
- XM_MemWrite  out  1  registered MemWrite
- XM_ALUout  out  32  registered ALU result
- XM_MD  out  32  registered store data
- XM_RD  out  5  registered destination
- pc_redirect  out  1  one-cycle pulse: fetch loads pc_target
- pc_target  out  32  redirect address
- squashing  out  1  high while squash count is nonzero
- taken_cnt  out  CNT_W  saturating count of redirects issued

Behaviour:
- Reset (async): every output is 0; squash counter is 0. Reset mid-squash abandons the squash.
- Latency: all outputs are registered; inputs sampled at posedge N appear after posedge N.
- ALU, 32-bit, wrap-around, overflow ignored:
  - 010 A+B; 110 A-B; 000 A&B; 001 A|B.
  - 111 slt: signed A<B gives 1, else 0.
  - 101 A-B.
  - 100 and 011: result 0.
- zero = (ALU result == 0).
- Branch taken when branch=1 and either (ALUctr=101 and zero) [beq] or (ALUctr=110 and not zero) [bne].
  - branch=1 with any other ALUctr is never taken.
- Branch target = NPC + (sign_extend(imm) << 2), modulo 2^32.
- Jump: jump=1 is always taken; target = JT. If jump and branch are both 1, jump wins.
- Data path registered every cycle: XM_ALUout, XM_MD=MD, XM_RD=RD.
- Squash counter, per cycle:
  - If counter > 0: the incoming instruction is squashed.
    - Squashed means XM_RegWrite, XM_MemRead, XM_MemWrite, XM_MemtoReg and pc_redirect are forced 0.
    - The counter decrements.
    - A taken branch/jump in a squashed slot is ignored: no redirect, no reload, no count.
  - Else if the instruction is taken:
    - pc_redirect=1 and pc_target=target for exactly one cycle.
    - Counter loads FLUSH_DEPTH.
    - The taken instruction's own control bits pass through unchanged.
  - Else: controls pass through, pc_redirect=0. pc_target holds its last value.
- squashing = (counter != 0), registered alongside the counter.
- FLUSH_DEPTH=0: no squashing, redirect only.
- Back-to-back taken instructions: the second is squashed when FLUSH_DEPTH>=1.
- taken_cnt: increments on each issued redirect; saturates at all-ones and never wraps.

Test Plan:
- Reset mid-operation: assert rst while squashing=1 -> all outputs 0 immediately; first non-branch after release passes controls unchanged.
- ALU: ALUctr=010, A=1, B=2 -> XM_ALUout=3. ALUctr=111, A=0xFFFFFFFF, B=1 -> 1. ALUctr=110, A=0, B=1 -> 0xFFFFFFFF.
- beq taken: branch=1, ALUctr=101, A=B=5, NPC=0x40, imm=0xFFFE:
  - next cycle: pc_redirect=1, pc_target=0x38, taken_cnt=1.
  - next two instructions (RegWrite=1, MemWrite=1) emerge with both 0; third passes unchanged.
- bne not taken: ALUctr=110, A=B=7 -> pc_redirect stays 0, no squash. Same with A=7, B=3, NPC=0x100, imm=4 -> pc_target=0x110.
- Jump followed immediately by a taken beq (FLUSH_DEPTH=2): exactly one redirect, to JT=0x00400020; beq is squashed; taken_cnt increments by 1.
- Counter saturation with CNT_W=2: five redirects -> taken_cnt=3 after the third redirect and stays 3.
